// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction control: one instruction in flight, stepped through
// DECODE, EXEC, MEM and WB with registered per-state datapath strobes.
module multicycle_control_unit #(
    parameter int INSTR_W     = 8,
    parameter int OP_W        = 4,
    parameter int REG_ADDR_W  = 2,
    parameter int SEL_W       = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instruction,
    output logic                  instr_ready,
    input  logic                  alu_zero,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] reg_addr_0,
    output logic [REG_ADDR_W-1:0] reg_addr_1,
    output logic [REG_ADDR_W-1:0] reg_addr_w,
    output logic [OP_W-1:0]       alu_op,
    output logic [SEL_W-1:0]      sel_w_source,
    output logic                  reg_w_en,
    output logic                  link_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic                  pc_en,
    output logic                  pc_load,
    output logic                  mem_err,
    output logic                  busy,
    output logic [CNT_W-1:0]      instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [OP_W-1:0] OP_MOVE = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(4'hB);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4'hC);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4'hD);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4'hE);
    localparam logic [OP_W-1:0] OP_LI   = OP_W'(4'hF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    state_t                state_r;
    logic [INSTR_W-1:0]    instr_r;
    logic [WAIT_W-1:0]     wait_cnt_r;
    logic [OP_W-1:0]       op_s;
    logic [REG_ADDR_W-1:0] field_0_s;
    logic [REG_ADDR_W-1:0] field_1_s;
    logic                  timeout_s;

    // Write-back register: the B field for single-destination ops, the link
    // register for jal, and zero for three-operand ALU ops and non-writers.
    function automatic logic [REG_ADDR_W-1:0] wb_addr(
        input logic [OP_W-1:0]       op,
        input logic [REG_ADDR_W-1:0] f1
    );
        case (op)
            OP_MOVE, OP_NOT, OP_SLL, OP_SRL, OP_LW, OP_ADDI, OP_LI: wb_addr = f1;
            OP_JAL:  wb_addr = '1;
            default: wb_addr = '0;
        endcase
    endfunction

    assign op_s      = instr_r[INSTR_W-1 -: OP_W];
    assign field_0_s = instr_r[REG_ADDR_W-1:0];
    assign field_1_s = instr_r[2*REG_ADDR_W-1:REG_ADDR_W];
    assign timeout_s = (MEM_TIMEOUT != 0) && (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1));

    assign instr_ready = ~rst & (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);

    // Sequencer: state, latched fields, registered strobes and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            instr_r      <= '0;
            wait_cnt_r   <= '0;
            reg_addr_0   <= '0;
            reg_addr_1   <= '0;
            reg_addr_w   <= '0;
            alu_op       <= '0;
            sel_w_source <= '0;
            reg_w_en     <= 1'b0;
            link_en      <= 1'b0;
            mem_r_en     <= 1'b0;
            mem_w_en     <= 1'b0;
            pc_en        <= 1'b0;
            pc_load      <= 1'b0;
            mem_err      <= 1'b0;
            instr_count  <= '0;
        end else begin
            reg_w_en <= 1'b0;
            link_en  <= 1'b0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            pc_en    <= 1'b0;
            pc_load  <= 1'b0;
            mem_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_r <= instruction;
                        state_r <= ST_DECODE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    reg_addr_0   <= field_0_s;
                    reg_addr_1   <= field_1_s;
                    reg_addr_w   <= wb_addr(op_s, field_1_s);
                    alu_op       <= op_s;
                    sel_w_source <= (op_s == OP_LW) ? '1 : '0;
                    state_r      <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (alu_op)
                        OP_J: begin
                            pc_load     <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                            state_r     <= ST_IDLE;
                        end
                        OP_LW: begin
                            mem_r_en   <= 1'b1;
                            wait_cnt_r <= '0;
                            state_r    <= ST_MEM;
                        end
                        OP_SW: begin
                            mem_w_en   <= 1'b1;
                            wait_cnt_r <= '0;
                            state_r    <= ST_MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            // Taken when the flag matches the branch sense.
                            if (alu_zero == (alu_op == OP_BEQ)) begin
                                pc_load <= 1'b1;
                            end else begin
                                pc_en <= 1'b1;
                            end
                            instr_count <= instr_count + CNT_W'(1);
                            state_r     <= ST_IDLE;
                        end
                        default: state_r <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (alu_op == OP_LW) begin
                            state_r <= ST_WB;
                        end else begin
                            pc_en       <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                            state_r     <= ST_IDLE;
                        end
                    end else if (timeout_s) begin
                        mem_err     <= 1'b1;
                        pc_en       <= 1'b1;
                        instr_count <= instr_count + CNT_W'(1);
                        state_r     <= ST_IDLE;
                    end else begin
                        mem_r_en   <= (alu_op == OP_LW);
                        mem_w_en   <= (alu_op != OP_LW);
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                        state_r    <= ST_MEM;
                    end
                end
                ST_WB: begin
                    reg_w_en <= 1'b1;
                    if (alu_op == OP_JAL) begin
                        link_en <= 1'b1;
                        pc_load <= 1'b1;
                    end else begin
                        pc_en <= 1'b1;
                    end
                    instr_count <= instr_count + CNT_W'(1);
                    state_r     <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus random
// instructions compared against a per-instruction timing model.
module tb_multicycle_control_unit;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instruction = 8'h00;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       instr_ready;
    logic [1:0] reg_addr_0, reg_addr_1, reg_addr_w;
    logic [3:0] alu_op;
    logic [7:0] sel_w_source;
    logic       reg_w_en, link_en, mem_r_en, mem_w_en, pc_en, pc_load, mem_err, busy;
    logic [15:0] instr_count;

    logic       instr_valid2 = 1'b0;
    logic [7:0] instruction2 = 8'h00;
    logic       instr_ready2;
    logic [1:0] reg_addr_02, reg_addr_12, reg_addr_w2;
    logic [3:0] alu_op2;
    logic [7:0] sel_w_source2;
    logic       reg_w_en2, link_en2, mem_r_en2, mem_w_en2, pc_en2, pc_load2, mem_err2, busy2;
    logic [1:0] instr_count2;

    int n_checks = 0;
    int n_fail   = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.INSTR_W(8), .OP_W(4), .REG_ADDR_W(2), .SEL_W(8),
                              .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
        .instr_ready(instr_ready), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1), .reg_addr_w(reg_addr_w),
        .alu_op(alu_op), .sel_w_source(sel_w_source), .reg_w_en(reg_w_en),
        .link_en(link_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .pc_en(pc_en),
        .pc_load(pc_load), .mem_err(mem_err), .busy(busy), .instr_count(instr_count)
    );

    multicycle_control_unit #(.INSTR_W(8), .OP_W(4), .REG_ADDR_W(2), .SEL_W(8),
                              .MEM_TIMEOUT(0), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst(rst), .instr_valid(instr_valid2), .instruction(instruction2),
        .instr_ready(instr_ready2), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .reg_addr_0(reg_addr_02), .reg_addr_1(reg_addr_12), .reg_addr_w(reg_addr_w2),
        .alu_op(alu_op2), .sel_w_source(sel_w_source2), .reg_w_en(reg_w_en2),
        .link_en(link_en2), .mem_r_en(mem_r_en2), .mem_w_en(mem_w_en2), .pc_en(pc_en2),
        .pc_load(pc_load2), .mem_err(mem_err2), .busy(busy2), .instr_count(instr_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction and check every cycle until it retires.
    // d = number of MEM wait cycles before mem_ready (>= TO means never).
    task automatic run_instr(input logic [7:0] ins, input logic az, input int d);
        logic [3:0] op;
        logic [1:0] f0, f1, exp_wa;
        logic       is_lw, is_sw, mem_op, to;
        logic [4:0] exp_strb;
        int         r, m, guard;
        op = ins[7:4];
        f0 = ins[1:0];
        f1 = ins[3:2];
        is_lw  = (op == 4'hA);
        is_sw  = (op == 4'hB);
        mem_op = is_lw | is_sw;
        to     = mem_op && (d >= TO);
        m      = 0;
        // strobe order: {reg_w_en, link_en, pc_en, pc_load, mem_err}
        if (op inside {4'h0, 4'h3, 4'h6, 4'h7, 4'hA, 4'hE, 4'hF}) exp_wa = f1;
        else if (op == 4'h9) exp_wa = 2'b11;
        else exp_wa = 2'b00;
        if (op == 4'h8) begin
            r = 2; exp_strb = 5'b00010;
        end else if (op == 4'hC || op == 4'hD) begin
            r = 2;
            exp_strb = ((op == 4'hC) == az) ? 5'b00010 : 5'b00100;
        end else if (op == 4'h9) begin
            r = 3; exp_strb = 5'b11010;
        end else if (to) begin
            m = TO; r = 2 + TO; exp_strb = 5'b00101;
        end else if (is_lw) begin
            m = d + 1; r = d + 4; exp_strb = 5'b10100;
        end else if (is_sw) begin
            m = d + 1; r = d + 3; exp_strb = 5'b00100;
        end else begin
            r = 3; exp_strb = 5'b10100;
        end
        model_count = (model_count + 1) % 65536;

        @(negedge clk);
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        instruction = ins;
        instr_valid = 1'b1;
        alu_zero    = az;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k <= r; k++) begin
            check($sformatf("strobes_%02h_k%0d", ins, k),
                  32'({reg_w_en, link_en, pc_en, pc_load, mem_err}),
                  32'((k == r) ? exp_strb : 5'b00000));
            check($sformatf("mem_en_%02h_k%0d", ins, k), 32'({mem_r_en, mem_w_en}),
                  32'((k >= 2 && k < 2 + m) ? {is_lw, is_sw} : 2'b00));
            check($sformatf("busy_%02h_k%0d", ins, k), 32'(busy), 32'(k < r));
            if (k == 1) check($sformatf("decode_op_%02h", ins), 32'(alu_op), 32'(op));
            if (k == r) begin
                check($sformatf("fields_%02h", ins),
                      32'({reg_addr_0, reg_addr_1, reg_addr_w, alu_op, sel_w_source}),
                      32'({f0, f1, exp_wa, op, (is_lw ? 8'hFF : 8'h00)}));
                check($sformatf("count_%02h", ins), 32'(instr_count), 32'(model_count));
                check($sformatf("ready_after_%02h", ins), 32'(instr_ready), 32'd1);
            end
            // Offers while busy must be ignored; drop the offer at retire.
            instr_valid = (k < r) ? 1'($urandom_range(0, 1)) : 1'b0;
            instruction = 8'($urandom);
            mem_ready   = mem_op && !to && (k == d + 2);
            if (k < r) begin
                @(posedge clk);
                #1;
            end
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_outputs",
              32'({reg_w_en, link_en, pc_en, pc_load, mem_err, mem_r_en, mem_w_en, busy, instr_ready}),
              32'd0);
        check("reset_fields", 32'({reg_addr_0, reg_addr_1, reg_addr_w, alu_op, sel_w_source}), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_release", 32'(instr_ready), 32'd1);

        run_instr(8'h1D, 1'b0, 0);   // add
        run_instr(8'hAD, 1'b0, 3);   // lw, ready on 4th MEM cycle (timeout boundary)
        run_instr(8'hCD, 1'b1, 0);   // beq taken
        run_instr(8'hDD, 1'b1, 0);   // bne not taken
        run_instr(8'h9D, 1'b0, 0);   // jal
        run_instr(8'hBD, 1'b0, 99);  // sw, memory never responds
        run_instr(8'h8D, 1'b0, 0);   // j

        // Reset in the middle of an lw memory wait.
        @(negedge clk);
        instruction = 8'hAD;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_rst_in_mem", 32'(mem_r_en), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs",
              32'({reg_w_en, link_en, pc_en, pc_load, mem_err, mem_r_en, mem_w_en, busy, instr_ready}),
              32'd0);
        check("mid_rst_fields", 32'({reg_addr_0, reg_addr_1, reg_addr_w, alu_op, sel_w_source}), 32'd0);
        check("mid_rst_count", 32'(instr_count), 32'd0);
        model_count = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_release", 32'(instr_ready), 32'd1);
        run_instr(8'h1D, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_instr(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
        end

        // Counter wrap on the CNT_W=2 instance with back-to-back adds.
        check("wrap_start_count", 32'(instr_count2), 32'd0);
        @(negedge clk);
        instruction2 = 8'h1D;
        instr_valid2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 15) begin
                check("wrap_count_4", 32'(instr_count2), 32'd0);
                check("wrap_pc_en_4", 32'(pc_en2), 32'd1);
            end
            if (i == 19) begin
                instr_valid2 = 1'b0;
                check("wrap_count_5", 32'(instr_count2), 32'd1);
                check("wrap_pc_en_5", 32'(pc_en2), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        check("wrap_idle_after", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the team's combinational instruction decoder. It accepts one instruction per valid/ready handshake and steps it through decode, execute, memory and write-back states. It drives register-file addresses, ALU opcode, memory enables, register write-back and PC control with per-state timing. It sits between the instruction fetch path and the datapath (register file, ALU, data memory, PC).

## Interface
- INSTR_W, 8, instruction width; must satisfy INSTR_W >= OP_W + 2*REG_ADDR_W
- OP_W, 4, opcode width; opcode = instruction[INSTR_W-1 -: OP_W]
- REG_ADDR_W, 2, register address width
- SEL_W, 8, width of sel_w_source
- MEM_TIMEOUT, 15, max MEM cycles before abort; 0 disables timeout
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction offered
- instruction  in  INSTR_W  instruction word
- instr_ready  out  1  block can accept an instruction
- alu_zero  in  1  ALU equality flag, sampled in EXEC
- mem_ready  in  1  data-memory access complete
- reg_addr_0  out  REG_ADDR_W  source A = instruction[REG_ADDR_W-1:0]
- reg_addr_1  out  REG_ADDR_W  source B = instruction[2*REG_ADDR_W-1:REG_ADDR_W]
- reg_addr_w  out  REG_ADDR_W  write-back address
- alu_op  out  OP_W  latched opcode to ALU
- sel_w_source  out  SEL_W  all-ones for lw (memory data), else 0
- reg_w_en  out  1  register write strobe
- link_en  out  1  write PC+1 instead of ALU/memory result (jal)
- mem_r_en / mem_w_en  out  1  memory read / write request
- pc_en  out  1  PC increment strobe
- pc_load  out  1  PC load-target strobe
- mem_err  out  1  memory timeout strobe
- busy  out  1  instruction in flight
- instr_count  out  CNT_W  retired instruction count

## Operation
- Opcode map:
  - 0 move, 1 add, 2 and, 3 not, 4 nor, 5 slt, 6 sll, 7 srl
  - 8 j, 9 jal, A lw, B sw, C beq, D bne, E addi, F li
- reg_addr_w by class:
  - reg_addr_1 field for move/not/sll/srl/lw/addi/li.
  - 0 for add/and/nor/slt.
  - All-ones (link register) for jal.
  - 0 for j/sw/beq/bne.
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE:
  - instr_ready = ~rst.
  - On instr_valid & instr_ready, latch instruction and go to DECODE.
- DECODE:
  - Register the address fields, alu_op and sel_w_source from the latched word.
  - These stay stable until the next accept.
  - Always goes to EXEC.
- EXEC, by opcode:
  - ALU ops (0–7, E, F): go to WB.
  - j: pc_load pulse, then IDLE.
  - jal: go to WB.
  - lw/sw: go to MEM.
  - beq: pc_load if alu_zero=1, else pc_en; then IDLE.
  - bne: pc_load if alu_zero=0, else pc_en; then IDLE.
- MEM:
  - mem_r_en (lw) or mem_w_en (sw) is held high every MEM cycle, including the cycle mem_ready=1.
  - On mem_ready: lw goes to WB; sw pulses pc_en and goes to IDLE.
  - Wait counter clears on MEM entry and increments each MEM cycle without mem_ready.
  - Timeout: in MEM cycle number MEM_TIMEOUT, if mem_ready=0, pulse mem_err and pc_en, skip write-back, go to IDLE.
  - mem_ready=1 in that same cycle wins (no error).
- WB:
  - reg_w_en pulse.
  - jal: additionally link_en and pc_load.
  - Others: pc_en.
  - Then IDLE.
- Retire and count:
  - Every instruction retires with exactly one pc_en or pc_load pulse, never both.
  - instr_count increments on that cycle and wraps modulo 2^CNT_W.
- busy = state != IDLE.
- Strobes (reg_w_en, link_en, pc_en, pc_load, mem_err) are single-cycle and depend only on state, latched opcode, alu_zero and mem_ready.

## Timing
- Reset (async, immediate):
  - state = IDLE.
  - All outputs 0, including instr_count, register addresses, alu_op and sel_w_source.
  - instr_ready is 0 while rst=1 and 1 in the first cycle after release.
- Accept at edge T. Then:
  - ALU op: DECODE T+1, EXEC T+2, WB T+3 (reg_w_en, pc_en); ready again at T+4.
  - j/beq/bne: retire strobe at T+2; ready at T+3.
  - jal: WB at T+3.
  - lw, mem_ready in first MEM cycle: MEM T+3, WB T+4, ready T+5. Each wait cycle adds 1.
  - sw: retire in the MEM cycle that sees mem_ready.
- Back-to-back: instr_valid held high is accepted in the first IDLE cycle. At most one instruction is ever in flight.
- instruction and instr_valid are ignored when busy=1.
- Reset mid-instruction: aborts with no further strobes; instr_count clears.

## Test plan
- Reset, then add 8'h1D at T:
  - reg_addr_0=1, reg_addr_1=3, reg_addr_w=0, alu_op=1.
  - reg_w_en and pc_en at T+3; instr_count=1.
- lw 8'hAD with mem_ready delayed 3 cycles:
  - mem_r_en high 4 MEM cycles; sel_w_source=8'hFF; reg_addr_w=3.
  - reg_w_en one cycle after mem_ready.
- beq 8'hCD with alu_zero=1, then bne 8'hDD with alu_zero=1:
  - beq gives pc_load at T+2; bne gives pc_en at T+2; no reg_w_en.
- jal 8'h9D:
  - WB has reg_w_en, link_en and pc_load together; reg_addr_w=3; no pc_en.
- sw 8'hBD with mem_ready never asserted, MEM_TIMEOUT=4:
  - mem_w_en for 4 cycles, then mem_err and pc_en in the same cycle.
  - Back in IDLE; no reg_w_en.
- rst pulsed during lw MEM wait:
  - Outputs go 0 immediately; no reg_w_en; instr_count=0.
  - Next instruction is accepted normally.
- Also run instr_count wrap at CNT_W=2: 5 retires leave instr_count=1.
